iec_bus_cond: RTL and testbench

Parametrised IEC serial-bus front end for the drive logic. It synchronises and digitally filters N open-collector bus lines, then resolves each line's wired-AND level against the local drive outputs. It emits single-cycle edge events and counts rejected glitches per channel. It also generates the phi2 rising/falling clock enables that the CPU and VIAs run on, with a configurable divide ratio. It sits between the top-level bus pins and the drive CPU/VIA glue, and replaces the fixed 3-line, 2-stage filter and fixed divide-by-32 enable generator.

---
 rtl/iec_pkg.sv | 23 ++
 rtl/iec_line_filter.sv | 82 ++++++++
 rtl/iec_bus_cond.sv | 69 ++++++
 tb/tb_iec_bus_cond.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iec_pkg.sv
// Shared constants and helpers for the IEC bus conditioner: default sizing,
// channel indices and the saturating glitch-count arithmetic.
package iec_pkg;

  localparam int IEC_CHANNELS = 3;
  localparam int IEC_SYNC     = 2;
  localparam int IEC_FILTER   = 2;
  localparam int IEC_DIV      = 32;

  localparam int IEC_ATN  = 0;
  localparam int IEC_CLK  = 1;
  localparam int IEC_DATA = 2;

  localparam logic [7:0] GLITCH_MAX = 8'hFF;

  typedef logic [3:0] run_t;
  typedef logic [7:0] glitch_t;

  function automatic glitch_t glitch_inc(input glitch_t v);
    return (v == GLITCH_MAX) ? v : v + glitch_t'(1);
  endfunction

endpackage

// File: rtl/iec_line_filter.sv
// One IEC bus line: synchroniser, run-length deglitch filter, edge pulses
// and a saturating count of rejected glitches.
module iec_line_filter
  import iec_pkg::*;
#(
  parameter int SYNC_STAGES = IEC_SYNC,
  parameter int FILTER_LEN  = IEC_FILTER
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       bus_in,
  input  logic       clr_glitch,
  output logic       bus_q,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  localparam run_t RUN_LAST = run_t'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  run_t                   r_run;
  logic                   r_bus_q;
  logic                   r_rise;
  logic                   r_fall;
  glitch_t                r_glitch;

  logic w_s;
  logic w_differ;
  logic w_accept;
  logic w_glitch;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_s != r_bus_q);
  assign w_accept = w_differ && (r_run == RUN_LAST);
  // A run that ends before reaching the accept length was a glitch.
  assign w_glitch = !w_differ && (r_run != run_t'(0));

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus_in};
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_run   <= '0;
      r_bus_q <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differ) begin
        r_run <= '0;
      end else if (w_accept) begin
        r_bus_q <= w_s;
        r_run   <= '0;
        r_rise  <= w_s;
        r_fall  <= !w_s;
      end else begin
        r_run <= r_run + run_t'(1);
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (reset || clr_glitch) begin
      r_glitch <= '0;
    end else if (w_glitch) begin
      r_glitch <= glitch_inc(r_glitch);
    end
  end

  assign bus_q      = r_bus_q;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign glitch_cnt = r_glitch;

endmodule

// File: rtl/iec_bus_cond.sv
// IEC bus front end: per-line filtering and wired-AND resolution, plus the
// phi2 rising/falling clock-enable generator for the CPU and VIAs.
module iec_bus_cond
  import iec_pkg::*;
#(
  parameter int CHANNELS    = IEC_CHANNELS,
  parameter int SYNC_STAGES = IEC_SYNC,
  parameter int FILTER_LEN  = IEC_FILTER,
  parameter int DIV         = IEC_DIV
) (
  input  logic                  clk32,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   bus_in,
  input  logic [CHANNELS-1:0]   drive_out,
  input  logic                  clr_glitch,
  output logic [CHANNELS-1:0]   bus_q,
  output logic [CHANNELS-1:0]   wired,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [8*CHANNELS-1:0] glitch_cnt,
  output logic                  p2_rise,
  output logic                  p2_fall
);

  localparam int            D_W    = $clog2(DIV);
  localparam logic [D_W-1:0] D_LAST = D_W'(DIV - 1);
  localparam logic [D_W-1:0] D_HALF = D_W'(DIV / 2);

  logic [D_W-1:0] r_d;
  logic           r_p2_rise;
  logic           r_p2_fall;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_line
      iec_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
      ) u_line (
        .clk32      (clk32),
        .reset      (reset),
        .bus_in     (bus_in[gi]),
        .clr_glitch (clr_glitch),
        .bus_q      (bus_q[gi]),
        .rise       (rise[gi]),
        .fall       (fall[gi]),
        .glitch_cnt (glitch_cnt[8*gi +: 8])
      );
    end
  endgenerate

  // The bus as seen locally: our own pull-down wins over a released line.
  assign wired = bus_q & drive_out;

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_d       <= '0;
      r_p2_rise <= 1'b0;
      r_p2_fall <= 1'b0;
    end else begin
      r_d       <= (r_d == D_LAST) ? '0 : r_d + D_W'(1);
      r_p2_rise <= (r_d == '0);
      r_p2_fall <= (r_d == D_HALF);
    end
  end

  assign p2_rise = r_p2_rise;
  assign p2_fall = r_p2_fall;

endmodule

// File: tb/tb_iec_bus_cond.sv
// Bench for iec_bus_cond: two configurations checked every cycle against a
// history-based model, plus directed literal expectations.
module tb_iec_bus_cond;

  localparam int NI = 2;
  localparam int HN = 8192;

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic        reset;
  logic        clr;
  logic [2:0]  bus_in_a;
  logic [2:0]  drive_a;
  logic [1:0]  b_hi;
  logic [4:0]  bus_in_b;
  logic [4:0]  drive_b;

  logic [2:0]  bq_a, wired_a, rise_a, fall_a;
  logic [23:0] gc_a;
  logic        p2r_a, p2f_a;
  logic [4:0]  bq_b, wired_b, rise_b, fall_b;
  logic [39:0] gc_b;
  logic        p2r_b, p2f_b;

  assign bus_in_b = {b_hi, bus_in_a};

  iec_bus_cond #(.CHANNELS(3), .SYNC_STAGES(2), .FILTER_LEN(2), .DIV(32)) u_a (
    .clk32(clk32), .reset(reset), .bus_in(bus_in_a), .drive_out(drive_a),
    .clr_glitch(clr), .bus_q(bq_a), .wired(wired_a), .rise(rise_a), .fall(fall_a),
    .glitch_cnt(gc_a), .p2_rise(p2r_a), .p2_fall(p2f_a)
  );

  iec_bus_cond #(.CHANNELS(5), .SYNC_STAGES(2), .FILTER_LEN(1), .DIV(4)) u_b (
    .clk32(clk32), .reset(reset), .bus_in(bus_in_b), .drive_out(drive_b),
    .clr_glitch(clr), .bus_q(bq_b), .wired(wired_b), .rise(rise_b), .fall(fall_b),
    .glitch_cnt(gc_b), .p2_rise(p2r_b), .p2_fall(p2f_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model configuration per instance.
  function automatic int p_ch(input int i); return (i == 0) ? 3 : 5; endfunction
  function automatic int p_sy(input int i); return 2; endfunction
  function automatic int p_fl(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_dv(input int i); return (i == 0) ? 32 : 4; endfunction

  // Model: input history since the last reset, filter rule applied per edge.
  logic [7:0] m_hist [NI][HN];
  int         m_rk   [NI];
  logic [7:0] m_bq   [NI];
  logic [7:0] m_rise [NI];
  logic [7:0] m_fall [NI];
  logic       m_p2r  [NI];
  logic       m_p2f  [NI];
  int         m_run  [NI][8];
  int         m_gc   [NI][8];
  bit         m_valid = 1'b0;

  task automatic model_step(input int i, input logic rst, input logic [7:0] din, input logic clr_in);
    int e;
    logic [7:0] s;
    if (rst) begin
      m_rk[i]   = 0;
      m_bq[i]   = 8'hFF;
      m_rise[i] = 8'h00;
      m_fall[i] = 8'h00;
      m_p2r[i]  = 1'b0;
      m_p2f[i]  = 1'b0;
      for (int c = 0; c < 8; c++) begin
        m_run[i][c] = 0;
        m_gc[i][c]  = 0;
      end
    end else begin
      e = m_rk[i];
      m_hist[i][e % HN] = din;
      s = (e >= p_sy(i)) ? m_hist[i][(e - p_sy(i)) % HN] : 8'hFF;
      m_p2r[i]  = ((e % p_dv(i)) == 0);
      m_p2f[i]  = ((e % p_dv(i)) == p_dv(i) / 2);
      m_rise[i] = 8'h00;
      m_fall[i] = 8'h00;
      for (int c = 0; c < p_ch(i); c++) begin
        if (s[c] != m_bq[i][c]) begin
          m_run[i][c]++;
          if (m_run[i][c] == p_fl(i)) begin
            m_bq[i][c]  = s[c];
            m_run[i][c] = 0;
            if (s[c]) m_rise[i][c] = 1'b1;
            else      m_fall[i][c] = 1'b1;
          end
        end else begin
          if (m_run[i][c] > 0 && m_gc[i][c] < 255) m_gc[i][c]++;
          m_run[i][c] = 0;
        end
        if (clr_in) m_gc[i][c] = 0;
      end
      m_rk[i] = e + 1;
    end
  endtask

  // Compare process: sample inputs at the edge, check outputs 1 time unit later.
  initial begin
    logic       rst_s, clr_s;
    logic [2:0] da;
    logic [4:0] db;
    forever begin
      @(posedge clk32);
      rst_s = reset;
      clr_s = clr;
      da    = bus_in_a;
      db    = bus_in_b;
      #1;
      if (rst_s === 1'b1) m_valid = 1'b1;
      if (m_valid) begin
        model_step(0, rst_s, {5'h1F, da}, clr_s);
        model_step(1, rst_s, {3'h7, db}, clr_s);
        chk("A.bus_q",   64'(bq_a),    64'(m_bq[0][2:0]));
        chk("A.wired",   64'(wired_a), 64'(m_bq[0][2:0] & drive_a));
        chk("A.rise",    64'(rise_a),  64'(m_rise[0][2:0]));
        chk("A.fall",    64'(fall_a),  64'(m_fall[0][2:0]));
        chk("A.p2_rise", 64'(p2r_a),   64'(m_p2r[0]));
        chk("A.p2_fall", 64'(p2f_a),   64'(m_p2f[0]));
        for (int c = 0; c < 3; c++)
          chk("A.glitch_cnt", 64'(gc_a[8*c +: 8]), 64'(m_gc[0][c]));
        chk("B.bus_q",   64'(bq_b),    64'(m_bq[1][4:0]));
        chk("B.wired",   64'(wired_b), 64'(m_bq[1][4:0] & drive_b));
        chk("B.rise",    64'(rise_b),  64'(m_rise[1][4:0]));
        chk("B.fall",    64'(fall_b),  64'(m_fall[1][4:0]));
        chk("B.p2_rise", 64'(p2r_b),   64'(m_p2r[1]));
        chk("B.p2_fall", 64'(p2f_b),   64'(m_p2f[1]));
        for (int c = 0; c < 5; c++)
          chk("B.glitch_cnt", 64'(gc_b[8*c +: 8]), 64'(m_gc[1][c]));
      end
    end
  end

  task automatic tick();
    @(posedge clk32);
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    clr      = 1'b0;
    bus_in_a = 3'b111;
    b_hi     = 2'b11;
    drive_a  = 3'b111;
    drive_b  = 5'h1F;

    repeat (3) tick();
    chk("rst.bus_q",   64'(bq_a),  64'h7);
    chk("rst.fall",    64'(fall_a), 64'h0);
    chk("rst.glitch",  64'(gc_a),  64'h0);
    chk("rst.p2_rise", 64'(p2r_a), 64'h0);
    chk("rst.bus_q_b", 64'(bq_b),  64'h1F);

    // Phase generator after reset release; tick k lands just after edge k.
    reset = 1'b0;
    for (int k = 0; k <= 66; k++) begin
      tick();
      if (k == 0 || k == 32 || k == 64) chk("phase.p2_rise_hi", 64'(p2r_a), 64'h1);
      if (k == 1 || k == 31 || k == 16) chk("phase.p2_rise_lo", 64'(p2r_a), 64'h0);
      if (k == 16 || k == 48)           chk("phase.p2_fall_hi", 64'(p2f_a), 64'h1);
      if (k == 0 || k == 15 || k == 17) chk("phase.p2_fall_lo", 64'(p2f_a), 64'h0);
      if (k < 4) begin
        chk("phase.b_rise", 64'(p2r_b), (k == 0) ? 64'h1 : 64'h0);
        chk("phase.b_fall", 64'(p2f_b), (k == 2) ? 64'h1 : 64'h0);
      end
    end

    // CLK line falls: A latency 4, B latency 3.
    bus_in_a[1] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 2) chk("lat.b_before", 64'(bq_b), 64'h1F);
      if (j == 3) begin
        chk("lat.a_before", 64'(bq_a),   64'h7);
        chk("lat.b_bus_q",  64'(bq_b),   64'h1D);
        chk("lat.b_fall",   64'(fall_b), 64'h02);
      end
      if (j == 4) begin
        chk("lat.a_bus_q", 64'(bq_a),   64'h5);
        chk("lat.a_fall",  64'(fall_a), 64'h2);
        chk("lat.a_rise",  64'(rise_a), 64'h0);
      end
      if (j == 5) chk("lat.a_fall_once", 64'(fall_a), 64'h0);
    end
    bus_in_a[1] = 1'b1;
    repeat (6) tick();

    // Single-cycle glitch on DATA, then saturate and clear.
    bus_in_a[2] = 1'b0;
    tick();
    bus_in_a[2] = 1'b1;
    repeat (4) tick();
    chk("glitch.one",     64'(gc_a[23:16]), 64'd1);
    chk("glitch.bus_q",   64'(bq_a),        64'h7);
    chk("glitch.b_none",  64'(gc_b[23:16]), 64'd0);
    for (int r = 0; r < 299; r++) begin
      bus_in_a[2] = 1'b0;
      tick();
      bus_in_a[2] = 1'b1;
      tick();
    end
    repeat (4) tick();
    chk("glitch.sat",     64'(gc_a[23:16]), 64'd255);
    chk("glitch.sat_bq",  64'(bq_a),        64'h7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("glitch.clr",     64'(gc_a[23:16]), 64'd0);

    // Clear lands on the very edge that would count a glitch.
    bus_in_a[2] = 1'b0;
    tick();
    bus_in_a[2] = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("glitch.clr_prio", 64'(gc_a[23:16]), 64'd0);
    repeat (3) tick();
    chk("glitch.clr_hold", 64'(gc_a[23:16]), 64'd0);

    // Local pull-down shows on wired with no latency.
    drive_a = 3'b110;
    #1;
    chk("wired.drive",  64'(wired_a), 64'h6);
    chk("wired.bus_q",  64'(bq_a),    64'h7);
    drive_a = 3'b111;
    tick();

    // All three lines fall together, then rise together.
    bus_in_a = 3'b000;
    repeat (3) tick();
    chk("multi.fall_early", 64'(fall_a), 64'h0);
    tick();
    chk("multi.fall", 64'(fall_a), 64'h7);
    chk("multi.bq",   64'(bq_a),   64'h0);
    bus_in_a = 3'b111;
    repeat (4) tick();
    chk("multi.rise", 64'(rise_a), 64'h7);
    repeat (3) tick();

    // Reset arrives mid-run; the pending fall must be discarded.
    bus_in_a = 3'b000;
    repeat (3) tick();
    reset    = 1'b1;
    bus_in_a = 3'b111;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("midrst.bus_q", 64'(bq_a),   64'h7);
      chk("midrst.fall",  64'(fall_a), 64'h0);
    end

    // Upper channel on the 5-wide instance.
    b_hi = 2'b10;
    repeat (2) tick();
    chk("b.ch3_before", 64'(bq_b[3]), 64'h1);
    tick();
    chk("b.ch3_bus_q",  64'(bq_b),   64'h17);
    chk("b.ch3_fall",   64'(fall_b), 64'h08);
    b_hi = 2'b11;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
